video_scale_packer: RTL and testbench

- Parametrised successor to the fixed 1/16 and 9/16 camera sampler.
- Decimates an incoming RGB565 stream to a run-time-selected scale, packs the kept pixels into DDR-width words and buffers them in an internal synchronous FIFO.
- Raises a burst request with a channel tag when a full burst is available.
- Sits between a camera/HDMI input channel and the multi-channel DDR write arbiter. CDC is done downstream.

---
 rtl/video_scale_packer_if.sv | 29 ++
 rtl/video_scale_packer.sv | 162 ++++++++++++++++
 tb/tb_video_scale_packer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_scale_packer_if.sv
// Stream-side bundle for video_scale_packer: sync/enable/pixel input, scale select,
// packed word output with show-ahead handshake, and burst/overflow status.
interface video_scale_packer_if #(
  parameter int PIX_WIDTH = 16,
  parameter int OUT_WIDTH = 256
);
  logic                 vs_in;
  logic                 de_in;
  logic [PIX_WIDTH-1:0] pix_in;
  logic [1:0]           scale_sel;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 burst_req;
  logic [3:0]           trans_id;
  logic                 overflow;
  logic [15:0]          drop_cnt;

  modport master (
    output vs_in, de_in, pix_in, scale_sel, out_ready,
    input  out_data, out_valid, out_sof, burst_req, trans_id, overflow, drop_cnt
  );

  modport slave (
    input  vs_in, de_in, pix_in, scale_sel, out_ready,
    output out_data, out_valid, out_sof, burst_req, trans_id, overflow, drop_cnt
  );
endinterface

// File: rtl/video_scale_packer.sv
// Decimates an RGB565 stream per axis, packs kept pixels into OUT_WIDTH words and
// buffers them in a show-ahead FIFO that raises a tagged burst request.
module video_scale_packer #(
  parameter int         PIX_WIDTH    = 16,
  parameter int         OUT_WIDTH    = 256,
  parameter int         VIDEO_WIDTH  = 1280,
  parameter int         VIDEO_HEIGHT = 720,
  parameter int         FIFO_DEPTH   = 64,
  parameter int         BURST_WORDS  = 8,
  parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  video_scale_packer_if.slave  bus
);
  localparam int PPW = OUT_WIDTH / PIX_WIDTH;
  localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int XW  = (VIDEO_WIDTH > 1) ? $clog2(VIDEO_WIDTH) : 1;
  localparam int YW  = (VIDEO_HEIGHT > 1) ? $clog2(VIDEO_HEIGHT) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW  = AW + 1;

  typedef enum logic [1:0] {
    SCALE_FULL    = 2'd0,
    SCALE_HALF    = 2'd1,
    SCALE_QUARTER = 2'd2,
    SCALE_3_4     = 2'd3
  } scale_e;

  function automatic logic phase_kept(scale_e m, logic [1:0] ph);
    case (m)
      SCALE_FULL:    return 1'b1;
      SCALE_HALF:    return ~ph[0];
      SCALE_QUARTER: return ph == 2'd0;
      default:       return ph != 2'd3;
    endcase
  endfunction

  logic                 vs_d, armed, sof_pending;
  scale_e               scale_q;
  logic                 de_s1, de_s2;
  logic [PIX_WIDTH-1:0] pix_s1;
  logic [XW-1:0]        col_idx;
  logic [YW-1:0]        line_idx;
  logic [OUT_WIDTH-1:0] pack, pack_next, wr_word;
  logic [CW-1:0]        pix_cnt;
  logic                 wr_en;
  logic [FW-1:0]        wr_ptr, rd_ptr, fill;
  logic [OUT_WIDTH:0]   mem [FIFO_DEPTH];
  logic [OUT_WIDTH:0]   head;
  logic                 burst_q, overflow_q;
  logic [3:0]           trans_q;
  logic [15:0]          drop_q;

  logic frame_start, empty, full, pop, push_ok, drop, keep, de_fall, word_done, burst_next;

  always_comb begin
    frame_start = bus.vs_in & ~vs_d;
    fill        = wr_ptr - rd_ptr;
    empty       = (fill == '0);
    full        = (fill == FW'(FIFO_DEPTH));
    pop         = ~empty & bus.out_ready;
    push_ok     = wr_en & (~full | pop);
    drop        = wr_en & full & ~pop;
    burst_next  = (fill >= FW'(BURST_WORDS));
    keep        = armed & de_s1 & phase_kept(scale_q, line_idx[1:0])
                                & phase_kept(scale_q, col_idx[1:0]);
    de_fall     = armed & ~de_s1 & de_s2;
    pack_next   = pack;
    for (int unsigned i = 0; i < PPW; i++) begin
      if (keep && pix_cnt == CW'(i)) pack_next[i*PIX_WIDTH +: PIX_WIDTH] = pix_s1;
    end
    word_done   = (keep && pix_cnt == CW'(PPW - 1)) || (de_fall && pix_cnt != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_d        <= 1'b0;
      de_s1       <= 1'b0;
      de_s2       <= 1'b0;
      pix_s1      <= '0;
      armed       <= 1'b0;
      sof_pending <= 1'b0;
      scale_q     <= SCALE_FULL;
      col_idx     <= '0;
      line_idx    <= '0;
      pack        <= '0;
      pix_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_word     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      burst_q     <= 1'b0;
      trans_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      vs_d   <= bus.vs_in;
      de_s1  <= bus.de_in;
      pix_s1 <= bus.pix_in;
      de_s2  <= de_s1;
      if (frame_start) begin
        armed       <= 1'b1;
        sof_pending <= 1'b1;
        scale_q     <= scale_e'(bus.scale_sel);
        col_idx     <= '0;
        line_idx    <= '0;
        pack        <= '0;
        pix_cnt     <= '0;
        wr_en       <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        burst_q     <= 1'b0;
        trans_q     <= '0;
        overflow_q  <= 1'b0;
        drop_q      <= '0;
      end else begin
        // Counters wrap at the active size; sizes are multiples of 4 so phase is unaffected.
        if (de_fall) begin
          col_idx  <= '0;
          line_idx <= (line_idx == YW'(VIDEO_HEIGHT - 1)) ? '0 : line_idx + 1'b1;
        end else if (armed && de_s1) begin
          col_idx  <= (col_idx == XW'(VIDEO_WIDTH - 1)) ? '0 : col_idx + 1'b1;
        end
        wr_en <= word_done;
        if (word_done) begin
          wr_word <= pack_next;
          pack    <= '0;
          pix_cnt <= '0;
        end else if (keep) begin
          pack    <= pack_next;
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (push_ok) begin
          wr_ptr      <= wr_ptr + 1'b1;
          sof_pending <= 1'b0;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + 16'd1;
        end
        burst_q <= burst_next;
        trans_q <= burst_next ? IMAGE_TAG : 4'd0;
      end
    end
  end

  // Storage carries the start-of-frame flag alongside each word.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {sof_pending, wr_word};
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : head[OUT_WIDTH-1:0];
  assign bus.out_sof   = ~empty & head[OUT_WIDTH];
  assign bus.burst_req = burst_q;
  assign bus.trans_id  = trans_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_video_scale_packer.sv
// Directed frame sequence with random pixels and random pops, scored against a
// line-level model of decimation, word packing and FIFO drop behaviour.
module tb_video_scale_packer;
  localparam int PIXW  = 16;
  localparam int OUTW  = 256;
  localparam int PPW   = OUTW / PIXW;
  localparam int VW    = 40;
  localparam int VH    = 32;
  localparam int DEPTH = 64;
  localparam int BW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  video_scale_packer_if #(.PIX_WIDTH(PIXW), .OUT_WIDTH(OUTW)) bus ();

  video_scale_packer #(
    .PIX_WIDTH(PIXW), .OUT_WIDTH(OUTW), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH),
    .FIFO_DEPTH(DEPTH), .BURST_WORDS(BW), .IMAGE_TAG(4'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic            sof;
    logic [OUTW-1:0] data;
  } word_t;

  word_t           exp_q[$];
  logic [PIXW-1:0] line_px[$];
  int checks = 0;
  int errors = 0;
  int frame_mode = 0, line_no = 0, gen_idx = 0, keep_n = 0, exp_drops = 0, rdy_mode = 0;
  bit model_on = 1'b0;
  int modes[4] = '{2, 3, 1, 0};

  task automatic chk(input string tag, input logic [OUTW-1:0] got, input logic [OUTW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit kept(input int mode, input int idx);
    int ph = idx % 4;
    case (mode)
      0:       return 1'b1;
      1:       return ph == 0 || ph == 2;
      2:       return ph == 0;
      default: return ph != 3;
    endcase
  endfunction

  // Words a line should produce: kept pixels in order, chunked by PPW, zero padded.
  task automatic model_line();
    logic [PIXW-1:0] k[$];
    word_t e;
    if (kept(frame_mode, line_no)) begin
      foreach (line_px[i]) if (kept(frame_mode, i)) k.push_back(line_px[i]);
      for (int w = 0; w * PPW < k.size(); w++) begin
        e.data = '0;
        for (int j = 0; j < PPW && w * PPW + j < k.size(); j++)
          e.data[j*PIXW +: PIXW] = k[w*PPW + j];
        e.sof = (gen_idx == 0);
        if (gen_idx < keep_n) exp_q.push_back(e);
        else exp_drops++;
        gen_idx++;
      end
    end
    line_no++;
  endtask

  task automatic drive_line(input int n, input int pop_slot, input bit lat_chk);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(PIXW'($urandom));
    if (model_on) model_line();
    for (int s = 0; s < n + 8; s++) begin
      @(posedge clk); #1;
      bus.de_in  = (s < n);
      bus.pix_in = (s < n) ? line_px[s] : PIXW'($urandom);
      if (pop_slot >= 0)      bus.out_ready = (s == pop_slot);
      else if (rdy_mode == 2) bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
      else                    bus.out_ready = 1'b0;
      if (lat_chk && (s == n + 1 || s == n + 2)) begin
        @(negedge clk);
        chk((s == n + 1) ? "latency_before" : "latency_at", bus.out_valid, (s == n + 2));
      end
    end
  endtask

  task automatic start_frame(input int mode);
    @(posedge clk); #1;
    bus.scale_sel = 2'(mode);
    bus.vs_in     = 1'b1;
    bus.de_in     = 1'b0;
    @(posedge clk); #1;
    bus.vs_in = 1'b0;
    exp_q.delete();
    frame_mode = mode; line_no = 0; gen_idx = 0; exp_drops = 0;
    keep_n = 1000000; model_on = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      budget--;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_remaining"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_empty"}, bus.out_valid, 0);
  endtask

  always @(negedge clk) begin
    word_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", bus.out_data, e.data);
        chk("word_sof", bus.out_sof, e.sof);
      end
    end
  end

  initial begin
    bus.vs_in = 1'b0; bus.de_in = 1'b0; bus.pix_in = '0;
    bus.scale_sel = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_sof", bus.out_sof, 0);
    chk("rst_burst", bus.burst_req, 0);
    chk("rst_tid", bus.trans_id, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Lines before any vs_in produce nothing.
    rdy_mode = 2;
    repeat (2) drive_line(VW, -1, 0);
    @(negedge clk);
    chk("idle_before_vs", bus.out_valid, 0);

    // Output latency on a single full word, then random traffic.
    start_frame(0);
    rdy_mode = 0;
    drive_line(16, -1, 1);
    rdy_mode = 1;
    repeat (3) drive_line(VW, -1, 0);
    drain("lat");

    foreach (modes[m]) begin
      start_frame(modes[m]);
      rdy_mode = 1;
      repeat (8) drive_line(VW, -1, 0);
      drain("mode");
    end

    // Overflow with the consumer stalled.
    start_frame(0);
    rdy_mode = 0;
    keep_n = DEPTH;
    repeat (2) drive_line(VW, -1, 0);
    @(negedge clk);
    chk("burst_below", bus.burst_req, 0);
    chk("tid_below", bus.trans_id, 0);
    drive_line(VW, -1, 0);
    @(negedge clk);
    chk("burst_at", bus.burst_req, 1);
    chk("tid_at", bus.trans_id, 4'd1);
    repeat (18) drive_line(VW, -1, 0);
    @(negedge clk);
    chk("ovf_before_full", bus.overflow, 0);
    repeat (5) drive_line(VW, -1, 0);
    @(negedge clk);
    chk("ovf_set", bus.overflow, 1);
    chk("drop_cnt", bus.drop_cnt, exp_drops);
    chk("burst_full", bus.burst_req, 1);
    drain("ovf");
    @(negedge clk);
    chk("ovf_sticky", bus.overflow, 1);
    chk("drop_sticky", bus.drop_cnt, exp_drops);
    chk("burst_drained", bus.burst_req, 0);
    chk("tid_drained", bus.trans_id, 0);
    start_frame(0);
    @(negedge clk);
    chk("ovf_clear", bus.overflow, 0);
    chk("drop_clear", bus.drop_cnt, 0);

    // Fill to exactly DEPTH, then write and pop on the same edge.
    rdy_mode = 0;
    keep_n = DEPTH + 1;
    repeat (21) drive_line(VW, -1, 0);
    drive_line(16, -1, 0);
    @(negedge clk);
    chk("full_valid", bus.out_valid, 1);
    chk("full_nodrop", bus.drop_cnt, 0);
    drive_line(VW, 17, 0);
    @(negedge clk);
    chk("simul_drop", bus.drop_cnt, exp_drops);
    chk("simul_ovf", bus.overflow, 1);
    drain("simul");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("empty_pop_valid", bus.out_valid, 0);
    chk("empty_pop_data", bus.out_data, 0);
    chk("empty_pop_drop", bus.drop_cnt, exp_drops);

    // Asynchronous reset mid-line.
    start_frame(0);
    rdy_mode = 0;
    model_on = 1'b0;
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #1;
      bus.de_in = 1'b1; bus.pix_in = PIXW'($urandom); bus.out_ready = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_sof", bus.out_sof, 0);
    chk("arst_burst", bus.burst_req, 0);
    chk("arst_tid", bus.trans_id, 0);
    chk("arst_ovf", bus.overflow, 0);
    chk("arst_drop", bus.drop_cnt, 0);
    @(posedge clk); #1;
    bus.de_in = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    rdy_mode = 2;
    repeat (2) drive_line(VW, -1, 0);
    @(negedge clk);
    chk("post_rst_idle", bus.out_valid, 0);

    // scale_sel change mid-frame only takes effect at the next frame.
    start_frame(2);
    rdy_mode = 1;
    repeat (2) drive_line(VW, -1, 0);
    bus.scale_sel = 2'd0;
    repeat (6) drive_line(VW, -1, 0);
    drain("toggle");
    start_frame(0);
    rdy_mode = 1;
    repeat (2) drive_line(VW, -1, 0);
    drain("after_toggle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
